id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Operand-issue pipeline stage directly upstream of the execute-stage ALU. Captures a decoded instruction from decode and holds it while downstream stalls. Resolves RAW hazards against the EX/MEM and MEM/WB stages by bypassing or by holding, and presents final ALU operands (`a`, `b`) and the `alu_ops` opcode. Branch resolution can flush it.

## Interface
Parameters: none (widths fixed by `rv32i_types`).

- `clk` in 1 — clock, all state on rising edge
- `rst_n` in 1 — synchronous, active-low reset
- `in_valid` in 1 — decode presents an instruction
- `in_ready` out 1 — stage accepts this cycle
- `in_aluop` in `alu_ops` — ALU operation
- `in_rs1`, `in_rs2` in 5 each — source indices; decode drives 0 when a source is unused
- `in_rs1_data`, `in_rs2_data` in 32 each — regfile read data
- `in_imm` in 32 — immediate
- `in_use_imm` in 1 — `b` comes from `imm`; rs2 is then not a hazard source
- `in_rd` in 5 — destination
- `in_is_load` in 1 — instruction is a load
- `in_pc` in 32 — instruction PC
- `flush` in 1 — kill held instruction and any capture this cycle
- `ex_ready` in 1 — execute accepts the presented instruction
- `exmem_valid`, `exmem_is_load` in 1 each; `exmem_rd` in 5; `exmem_result` in 32
- `memwb_valid` in 1; `memwb_rd` in 5; `memwb_result` in 32 — also the regfile write port this cycle
- `out_valid` out 1 — instruction presented with hazard-free operands
- `out_aluop` out `alu_ops`; `out_a`, `out_b` out 32 each; `out_rd` out 5; `out_is_load` out 1; `out_pc` out 32

## Operation
- Storage: one entry holding `held_valid` plus all `in_*` fields.
- Match condition: `X_hit(rs) = X_valid && X_rd == rs && rs != 0`.
- Hazard:
  - With bypass: `exmem_hit && exmem_is_load` on rs1, or on rs2 when `!use_imm`.
  - Without bypass: any `exmem_hit` or `memwb_hit` on a used source.
- `out_valid = held_valid && !hazard`.
- `in_ready = !held_valid || (ex_ready && out_valid)`.
- Capture: when `in_valid && in_ready && !flush`, load the entry and set `held_valid`.
- Advance without capture: `held_valid` clears on the same condition as a handshake.
- Flush: `held_valid <= 0` next cycle; overrides capture and handshake. `in_ready` is still computed normally, but the captured data is discarded.
- Writeback snoop: every cycle the entry is held and not replaced, `memwb_hit(held_rs1)` overwrites the stored `rs1_data` with `memwb_result`; same for rs2. This keeps operands valid after the producer retires.
- Operand muxes (combinational from entry):
  - `src1` = `exmem_result` if `exmem_hit`; else `memwb_result` if `memwb_hit`; else stored data. EX/MEM has priority.
  - `src2` is formed the same way.
  - `out_a = src1`; `out_b = use_imm ? imm : src2`.
- Remaining outputs come straight from the entry.

## Timing
- Reset: `held_valid` = 0 and all stored fields = 0. Hence `out_valid` = 0, `out_a`/`out_b`/`out_rd`/`out_pc` = 0, `out_aluop` = `alu_add` (encoding 0), `out_is_load` = 0, `in_ready` = 1.
- Reset asserted mid-stall drops the held instruction.
- Latency: capture at edge N gives `out_valid` after edge N (cycle N+1) if no hazard. Throughput is 1/cycle.
- Load-use with bypass: exactly 1 bubble. In the following cycle the load is in MEM/WB and is bypassed.
- Without bypass: stall until the producer's MEM/WB cycle has passed. The snoop captures the value, so the entry proceeds the cycle after.
- `out_*` must hold stable while `out_valid && !ex_ready`.
- Simultaneous hazard and flush: the flush wins and no bubble persists.

## Configuration
- `ID_EX_FORWARDING_EN` defined: the EX/MEM and MEM/WB bypass muxes are present. Hazards are load-use only.
- Not defined: no bypass paths; `out_a`/`out_b` come from stored data (with snoop). Hazard covers every in-flight producer. Functional results are identical; only stall counts differ.

## Test plan
- Reset with `rst_n` = 0 for 2 cycles → `out_valid` = 0, `in_ready` = 1, `out_a` = 0. Then x1 = 5 via regfile, `add` with `rs1` = 1, `imm` = 7, `use_imm` → next cycle `out_a` = 5, `out_b` = 7.
- Back-to-back RAW: `exmem_rd` = 3, `exmem_result` = 0x10, held `rs2` = 3, stored data 0 → with macro `out_b` = 0x10 and no stall. Without macro: `out_valid` = 0 for 2 cycles, then `out_b` = 0x10.
- Load-use: `exmem_is_load`, `exmem_rd` = 4, held `rs1` = 4 → `out_valid` = 0 for one cycle. Next cycle `memwb_rd` = 4, `memwb_result` = 0xDEAD → `out_valid` = 1, `out_a` = 0xDEAD.
- Downstream stall: `ex_ready` = 0 for 3 cycles while `memwb` writes x2 = 9 to held `rs1` = 2 → `in_ready` = 0 and outputs stable. After release `out_a` = 9 from the snoop.
- Flush concurrent with `in_valid`: `flush` = 1, `in_valid` = 1 → next cycle `out_valid` = 0 and nothing captured.
- x0 guard: `exmem_rd` = 0, `exmem_valid`, held `rs1` = 0 → no stall, `out_a` = stored data.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX operand-issue stage: one held instruction, RAW hazard stall, optional EX/MEM + MEM/WB bypass (ID_EX_FORWARDING_EN).
// Capture-to-out_valid is 1 cycle; entry and outputs hold while ex_ready is low; flush drops the entry.
package rv32i_types;
  typedef enum logic [3:0] {
    alu_add  = 4'd0,
    alu_sub  = 4'd1,
    alu_sll  = 4'd2,
    alu_slt  = 4'd3,
    alu_sltu = 4'd4,
    alu_xor  = 4'd5,
    alu_srl  = 4'd6,
    alu_sra  = 4'd7,
    alu_or   = 4'd8,
    alu_and  = 4'd9
  } alu_ops;
endpackage

module id_ex_stage
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  alu_ops      in_aluop,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  input  logic [4:0]  in_rd,
  input  logic        in_is_load,
  input  logic [31:0] in_pc,
  input  logic        flush,
  input  logic        ex_ready,
  input  logic        exmem_valid,
  input  logic        exmem_is_load,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_valid,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic        out_valid,
  output alu_ops      out_aluop,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [4:0]  out_rd,
  output logic        out_is_load,
  output logic [31:0] out_pc
);

  typedef struct packed {
    alu_ops      aluop;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  rd;
    logic        is_load;
    logic [31:0] pc;
  } entry_t;

  entry_t      ent;
  entry_t      ent_in;
  logic        held_valid;
  logic        ex_hit1, ex_hit2, wb_hit1, wb_hit2;
  logic        hazard;
  logic        capture;
  logic        handshake;
  logic [31:0] src1, src2;

  always_comb begin
    ent_in          = '0;
    ent_in.aluop    = in_aluop;
    ent_in.rs1      = in_rs1;
    ent_in.rs2      = in_rs2;
    ent_in.rs1_data = in_rs1_data;
    ent_in.rs2_data = in_rs2_data;
    ent_in.imm      = in_imm;
    ent_in.use_imm  = in_use_imm;
    ent_in.rd       = in_rd;
    ent_in.is_load  = in_is_load;
    ent_in.pc       = in_pc;
  end

  // x0 never matches: it is both the hardwired zero and the "no source" marker.
  assign ex_hit1 = exmem_valid && (exmem_rd == ent.rs1) && (ent.rs1 != 5'd0);
  assign ex_hit2 = exmem_valid && (exmem_rd == ent.rs2) && (ent.rs2 != 5'd0);
  assign wb_hit1 = memwb_valid && (memwb_rd == ent.rs1) && (ent.rs1 != 5'd0);
  assign wb_hit2 = memwb_valid && (memwb_rd == ent.rs2) && (ent.rs2 != 5'd0);

`ifdef ID_EX_FORWARDING_EN
  // Only a load still in EX/MEM has no value yet; everything else is bypassed.
  assign hazard = exmem_is_load && (ex_hit1 || (!ent.use_imm && ex_hit2));
  assign src1   = ex_hit1 ? exmem_result : (wb_hit1 ? memwb_result : ent.rs1_data);
  assign src2   = ex_hit2 ? exmem_result : (wb_hit2 ? memwb_result : ent.rs2_data);
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_is_load, exmem_result};
  assign hazard = ex_hit1 || wb_hit1 || (!ent.use_imm && (ex_hit2 || wb_hit2));
  assign src1   = ent.rs1_data;
  assign src2   = ent.rs2_data;
`endif

  assign out_valid = held_valid && !hazard;
  assign in_ready  = !held_valid || (ex_ready && out_valid);
  assign handshake = out_valid && ex_ready;
  assign capture   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_valid <= 1'b0;
      ent        <= '0;
    end else begin
      if (flush)
        held_valid <= 1'b0;
      else if (capture)
        held_valid <= 1'b1;
      else if (handshake)
        held_valid <= 1'b0;

      // Snoop the regfile write so a held operand survives its producer retiring.
      if (capture) begin
        ent <= ent_in;
      end else if (held_valid) begin
        if (wb_hit1) ent.rs1_data <= memwb_result;
        if (wb_hit2) ent.rs2_data <= memwb_result;
      end
    end
  end

  assign out_aluop   = ent.aluop;
  assign out_a       = src1;
  assign out_b       = ent.use_imm ? ent.imm : src2;
  assign out_rd      = ent.rd;
  assign out_is_load = ent.is_load;
  assign out_pc      = ent.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, multi-cycle hazard sequences, then random traffic vs a producer-list model.
module tb_id_ex_stage;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  alu_ops      in_aluop;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic        in_use_imm, in_is_load;
  logic        flush, ex_ready;
  logic        exmem_valid, exmem_is_load;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_valid;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        out_valid;
  alu_ops      out_aluop;
  logic [31:0] out_a, out_b, out_pc;
  logic [4:0]  out_rd;
  logic        out_is_load;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd), .in_is_load(in_is_load), .in_pc(in_pc),
    .flush(flush), .ex_ready(ex_ready),
    .exmem_valid(exmem_valid), .exmem_is_load(exmem_is_load), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_valid(memwb_valid), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_aluop(out_aluop), .out_a(out_a), .out_b(out_b),
    .out_rd(out_rd), .out_is_load(out_is_load), .out_pc(out_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; in_valid = 1'b0; in_aluop = alu_add;
    in_rs1 = '0; in_rs2 = '0; in_rs1_data = '0; in_rs2_data = '0;
    in_imm = '0; in_use_imm = 1'b0; in_rd = '0; in_is_load = 1'b0; in_pc = '0;
    flush = 1'b0; ex_ready = 1'b1;
    exmem_valid = 1'b0; exmem_is_load = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_valid = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  // One-cycle capture; leaves the entry held at the next negedge.
  task automatic issue(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                       input logic [31:0] d2, input logic ui, input logic [31:0] imm, input logic [4:0] rd);
    in_valid = 1'b1; in_rs1 = rs1; in_rs1_data = d1; in_rs2 = rs2; in_rs2_data = d2;
    in_use_imm = ui; in_imm = imm; in_rd = rd; in_pc = 32'h2000;
    #1;
    chk("issue.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    idle();
  endtask

  typedef struct {
    logic        rst_n, in_valid, flush, ex_ready, use_imm, exv;
    logic [4:0]  rs1, rs2, rd, exrd;
    logic [31:0] d1, d2, imm, exres;
    logic        e_valid, e_ready;
    logic [31:0] e_a, e_b;
    logic [4:0]  e_rd;
  } vec_t;

  function automatic vec_t vec(input logic r, input logic iv, input logic fl, input logic er,
                               input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                               input logic [31:0] d2, input logic ui, input logic [31:0] imm,
                               input logic [4:0] rd, input logic exv, input logic [4:0] exrd,
                               input logic [31:0] exres, input logic ev, input logic erdy,
                               input logic [31:0] ea, input logic [31:0] eb, input logic [4:0] erd);
    vec_t v;
    v.rst_n = r; v.in_valid = iv; v.flush = fl; v.ex_ready = er;
    v.rs1 = rs1; v.d1 = d1; v.rs2 = rs2; v.d2 = d2; v.use_imm = ui; v.imm = imm; v.rd = rd;
    v.exv = exv; v.exrd = exrd; v.exres = exres;
    v.e_valid = ev; v.e_ready = erdy; v.e_a = ea; v.e_b = eb; v.e_rd = erd;
    return v;
  endfunction

  // Reference model state: the single instruction the stage should be holding.
  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic        ui, ld;
  } ment_t;

  ment_t m;

  function automatic ment_t empty_ent();
    ment_t e;
    e.v = 1'b0; e.op = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0;
    e.d1 = '0; e.d2 = '0; e.imm = '0; e.pc = '0; e.ui = 1'b0; e.ld = 1'b0;
    return e;
  endfunction

  // Walk in-flight producers youngest first; the first writer of rs decides the operand.
  task automatic lookup(input logic [4:0] rs, input logic [31:0] stored,
                        output logic [31:0] val, output logic stall);
    logic        vld  [2];
    logic [4:0]  dst  [2];
    logic [31:0] res  [2];
    logic        late [2];
    logic        found;
    vld[0] = exmem_valid;  dst[0] = exmem_rd;  res[0] = exmem_result;  late[0] = exmem_is_load;
    vld[1] = memwb_valid;  dst[1] = memwb_rd;  res[1] = memwb_result;  late[1] = 1'b0;
    val = stored; stall = 1'b0; found = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (!found && vld[k] && dst[k] == rs && rs != 5'd0) begin
        found = 1'b1;
`ifdef ID_EX_FORWARDING_EN
        val = res[k];
        stall = late[k];
`else
        stall = 1'b1;
`endif
      end
    end
  endtask

  vec_t tbl [14];

  initial begin
    logic [31:0] a_val, b_src;
    logic        st1, st2, e_valid, e_ready, cap;

    tbl[0]  = vec(0,0,0,1, 0,0,        0,0,     0,0,     0,  0,0,0,        0,1,0,0,0);
    tbl[1]  = vec(1,1,0,1, 1,5,        0,0,     1,7,     2,  0,0,0,        0,1,0,0,0);
    tbl[2]  = vec(1,1,0,1, 0,'hAAAA,   0,'h33,  0,0,     5,  1,0,'hBAD,    1,1,5,7,2);
    tbl[3]  = vec(1,0,0,0, 0,0,        0,0,     0,0,     0,  1,0,'hBAD,    1,0,'hAAAA,'h33,5);
    tbl[4]  = vec(1,1,1,0, 0,1,        0,0,     1,2,     6,  0,0,0,        1,0,'hAAAA,'h33,5);
    tbl[5]  = vec(1,0,0,1, 0,0,        0,0,     0,0,     0,  0,0,0,        0,1,'hAAAA,'h33,5);
    tbl[6]  = vec(1,1,1,1, 0,3,        0,4,     0,0,     7,  0,0,0,        0,1,'hAAAA,'h33,5);
    tbl[7]  = vec(1,0,0,1, 0,0,        0,0,     0,0,     0,  0,0,0,        0,1,'hAAAA,'h33,5);
    tbl[8]  = vec(1,1,0,1, 0,'h11,     0,'h22,  0,0,     9,  0,0,0,        0,1,'hAAAA,'h33,5);
    tbl[9]  = vec(1,1,0,1, 0,'h44,     0,0,     1,'h55,  10, 0,0,0,        1,1,'h11,'h22,9);
    tbl[10] = vec(1,0,0,1, 0,0,        0,0,     0,0,     0,  0,0,0,        1,1,'h44,'h55,10);
    tbl[11] = vec(1,1,0,0, 0,'h66,     0,0,     1,'h77,  12, 0,0,0,        0,1,'h44,'h55,10);
    tbl[12] = vec(0,0,0,0, 0,0,        0,0,     0,0,     0,  0,0,0,        1,0,'h66,'h77,12);
    tbl[13] = vec(1,0,0,1, 0,0,        0,0,     0,0,     0,  0,0,0,        0,1,0,0,0);

    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      idle();
      rst_n = tbl[i].rst_n; in_valid = tbl[i].in_valid; flush = tbl[i].flush; ex_ready = tbl[i].ex_ready;
      in_rs1 = tbl[i].rs1; in_rs1_data = tbl[i].d1; in_rs2 = tbl[i].rs2; in_rs2_data = tbl[i].d2;
      in_use_imm = tbl[i].use_imm; in_imm = tbl[i].imm; in_rd = tbl[i].rd;
      exmem_valid = tbl[i].exv; exmem_rd = tbl[i].exrd; exmem_result = tbl[i].exres;
      #1;
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d.in_ready", i),  32'(in_ready),  32'(tbl[i].e_ready));
      chk($sformatf("vec%0d.out_a", i),     out_a,          tbl[i].e_a);
      chk($sformatf("vec%0d.out_b", i),     out_b,          tbl[i].e_b);
      chk($sformatf("vec%0d.out_rd", i),    32'(out_rd),    32'(tbl[i].e_rd));
      @(negedge clk);
    end

    // Back-to-back RAW on rs2.
    idle(); @(negedge clk);
    issue(0, 1, 3, 0, 0, 0, 8);
    exmem_valid = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h10;
    #1;
`ifdef ID_EX_FORWARDING_EN
    chk("raw.out_valid", 32'(out_valid), 32'd1);
    chk("raw.out_b", out_b, 32'h10);
    @(negedge clk); idle();
`else
    chk("raw.stall0", 32'(out_valid), 32'd0);
    @(negedge clk); idle();
    memwb_valid = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h10;
    #1;
    chk("raw.stall1", 32'(out_valid), 32'd0);
    @(negedge clk); idle();
    #1;
    chk("raw.out_valid", 32'(out_valid), 32'd1);
    chk("raw.out_b", out_b, 32'h10);
    @(negedge clk);
`endif

    // Load-use on rs1.
    idle(); @(negedge clk);
    issue(4, 0, 0, 0, 1, 1, 9);
    exmem_valid = 1'b1; exmem_is_load = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h0;
    #1;
    chk("lu.bubble", 32'(out_valid), 32'd0);
    @(negedge clk); idle();
    memwb_valid = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hDEAD;
    #1;
`ifdef ID_EX_FORWARDING_EN
    chk("lu.out_valid", 32'(out_valid), 32'd1);
    chk("lu.out_a", out_a, 32'hDEAD);
    @(negedge clk); idle();
`else
    chk("lu.stall1", 32'(out_valid), 32'd0);
    @(negedge clk); idle();
    #1;
    chk("lu.out_valid", 32'(out_valid), 32'd1);
    chk("lu.out_a", out_a, 32'hDEAD);
    @(negedge clk);
`endif

    // Downstream stall while x2 retires through the write port.
    idle(); @(negedge clk);
    issue(2, 0, 0, 0, 1, 3, 11);
    ex_ready = 1'b0; memwb_valid = 1'b1; memwb_rd = 5'd2; memwb_result = 32'd9;
    #1;
    chk("stall.c1.in_ready", 32'(in_ready), 32'd0);
`ifdef ID_EX_FORWARDING_EN
    chk("stall.c1.out_valid", 32'(out_valid), 32'd1);
    chk("stall.c1.out_a", out_a, 32'd9);
`else
    chk("stall.c1.out_valid", 32'(out_valid), 32'd0);
`endif
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk); idle();
      ex_ready = (c == 4);
      #1;
      chk($sformatf("stall.c%0d.out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall.c%0d.in_ready", c), 32'(in_ready), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("stall.c%0d.out_a", c), out_a, 32'd9);
      chk($sformatf("stall.c%0d.out_b", c), out_b, 32'd3);
      chk($sformatf("stall.c%0d.out_rd", c), 32'(out_rd), 32'd11);
    end
    @(negedge clk);

    // Random traffic against the model.
    idle(); rst_n = 1'b0;
    @(negedge clk);
    m = empty_ent();
    for (int n = 0; n < 2000; n++) begin
      rst_n        = ($urandom_range(0, 49) != 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      in_aluop     = alu_ops'(4'($urandom_range(0, 9)));
      in_rs1       = 5'($urandom_range(0, 3));
      in_rs2       = 5'($urandom_range(0, 3));
      in_rs1_data  = $urandom;
      in_rs2_data  = $urandom;
      in_imm       = $urandom;
      in_use_imm   = 1'($urandom_range(0, 1));
      in_rd        = 5'($urandom_range(0, 3));
      in_is_load   = 1'($urandom_range(0, 1));
      in_pc        = $urandom;
      flush        = ($urandom_range(0, 7) == 0);
      ex_ready     = ($urandom_range(0, 3) != 0);
      exmem_valid  = 1'($urandom_range(0, 1));
      exmem_is_load = ($urandom_range(0, 2) == 0);
      exmem_rd     = 5'($urandom_range(0, 3));
      exmem_result = $urandom;
      memwb_valid  = 1'($urandom_range(0, 1));
      memwb_rd     = 5'($urandom_range(0, 3));
      memwb_result = $urandom;
      #1;

      lookup(m.rs1, m.d1, a_val, st1);
      lookup(m.rs2, m.d2, b_src, st2);
      e_valid = m.v && !(st1 || (!m.ui && st2));
      e_ready = !m.v || (ex_ready && e_valid);
      chk($sformatf("rnd%0d.out_valid", n),   32'(out_valid),   32'(e_valid));
      chk($sformatf("rnd%0d.in_ready", n),    32'(in_ready),    32'(e_ready));
      chk($sformatf("rnd%0d.out_aluop", n),   32'(out_aluop),   32'(m.op));
      chk($sformatf("rnd%0d.out_a", n),       out_a,            a_val);
      chk($sformatf("rnd%0d.out_b", n),       out_b,            m.ui ? m.imm : b_src);
      chk($sformatf("rnd%0d.out_rd", n),      32'(out_rd),      32'(m.rd));
      chk($sformatf("rnd%0d.out_is_load", n), 32'(out_is_load), 32'(m.ld));
      chk($sformatf("rnd%0d.out_pc", n),      out_pc,           m.pc);

      if (!rst_n) begin
        m = empty_ent();
      end else begin
        cap = in_valid && e_ready && !flush;
        if (cap) begin
          m.v = 1'b1; m.op = in_aluop; m.rs1 = in_rs1; m.rs2 = in_rs2; m.rd = in_rd;
          m.d1 = in_rs1_data; m.d2 = in_rs2_data; m.imm = in_imm; m.pc = in_pc;
          m.ui = in_use_imm; m.ld = in_is_load;
        end else begin
          if (m.v && memwb_valid && memwb_rd == m.rs1 && m.rs1 != 5'd0) m.d1 = memwb_result;
          if (m.v && memwb_valid && memwb_rd == m.rs2 && m.rs2 != 5'd0) m.d2 = memwb_result;
          if (flush || (ex_ready && e_valid)) m.v = 1'b0;
        end
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
